// File: rtl/vector_add_acc_pkg.sv
// Shared types and helpers for the vector_add_acc datapath.
package vector_add_acc_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Low bit index of a lane within a packed multi-lane vector.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vadd_lane.sv
// Single-lane signed adder; wraps by default, saturates when VECTOR_ADD_ACC_SAT_EN is defined.
module vadd_lane #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

`ifdef VECTOR_ADD_ACC_SAT_EN
    logic [DATA_W:0] wide;

    always_comb begin
        wide = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
        // Top two bits disagree only on signed overflow; the extra bit carries the true sign.
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sum_o = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sum_o = wide[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/vector_add_acc.sv
// Lane-parallel vector adder / stream accumulator with valid/ready on both sides.
// Saturating lane arithmetic is enabled by defining VECTOR_ADD_ACC_SAT_EN.
module vector_add_acc
    import vector_add_acc_pkg::*;
#(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*DATA_W-1:0] in_a_i,
    input  logic [LANES*DATA_W-1:0] in_b_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]        out_count_o
);

    localparam int unsigned VecW = LANES * DATA_W;

    state_e            state_q;
    mode_e             mode_q;
    mode_e             eff_mode;
    logic [VecW-1:0]   acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              out_valid_q;
    logic [VecW-1:0]   out_data_q;
    logic [CNT_W-1:0]  out_count_q;
    logic [VecW-1:0]   add_b;
    logic [VecW-1:0]   sum;
    logic              in_fire;

    assign in_ready_o  = (state_q == ACCUM) || !out_valid_q || out_ready_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;

    // Inside a group the latched mode wins; the live input only matters on a group's first beat.
    assign eff_mode = (state_q == ACCUM) ? mode_q : mode_e'(mode_i);
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        add_b = '0;
        if (eff_mode == MODE_ADD) begin
            add_b = in_b_i;
        end else if (state_q == ACCUM) begin
            add_b = acc_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vadd_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .a_i  (in_a_i[lane_lo(i, DATA_W) +: DATA_W]),
            .b_i  (add_b[lane_lo(i, DATA_W) +: DATA_W]),
            .sum_o(sum[lane_lo(i, DATA_W) +: DATA_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ADD;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (in_fire) begin
                unique case (state_q)
                    IDLE: begin
                        mode_q <= mode_e'(mode_i);
                        if (mode_e'(mode_i) == MODE_ADD || in_last_i) begin
                            out_data_q  <= sum;
                            out_count_q <= CNT_W'(1);
                            out_valid_q <= 1'b1;
                        end else begin
                            acc_q   <= sum;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (in_last_i) begin
                            out_data_q  <= sum;
                            out_count_q <= cnt_inc;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            acc_q <= sum;
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_add_acc.sv
// Directed self-checking bench for vector_add_acc (default 16 x 32-bit lanes).
module tb_vector_add_acc;

    localparam int unsigned LANES  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [VW-1:0]     in_a = '0;
    logic [VW-1:0]     in_b = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [VW-1:0]     out_data;
    logic [CNT_W-1:0]  out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_add_acc #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (mode),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_count_o(out_count)
    );

    function automatic logic [VW-1:0] splat(input logic [DATA_W-1:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] ramp(input int base);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + i);
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic m, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic last);
        in_valid = 1'b1;
        mode     = m;
        in_a     = a;
        in_b     = b;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [VW-1:0] exp_v;
    logic [VW-1:0] mix_a;
    logic [VW-1:0] mix_b;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", VW'(out_count), '0);
        chk("rst_in_ready", VW'(in_ready), VW'(1'b1));
        rst = 1'b0;
        tick();

        // ADD: 16 back-to-back beats, lane i gets (i+k) + 100
        for (int k = 0; k < 16; k++) begin
            beat(1'b0, ramp(k), splat(32'd100), 1'b0);
            tick();
            chk($sformatf("add_valid_%0d", k), VW'(out_valid), VW'(1'b1));
            chk($sformatf("add_data_%0d", k), out_data, ramp(100 + k));
            chk($sformatf("add_count_%0d", k), VW'(out_count), VW'(1));
        end
        idle();
        tick();
        chk("add_drain", VW'(out_valid), VW'(1'b0));

        // ACC group of 4: 1+2+3+4 = 10, in_b random
        for (int j = 1; j <= 4; j++) begin
            beat(1'b1, splat(DATA_W'(j)), rnd_vec(), j == 4);
            tick();
            if (j < 4) chk($sformatf("acc4_nores_%0d", j), VW'(out_valid), VW'(1'b0));
        end
        chk("acc4_valid", VW'(out_valid), VW'(1'b1));
        chk("acc4_data", out_data, splat(32'd10));
        chk("acc4_count", VW'(out_count), VW'(4));
        idle();
        tick();

        // Backpressure: 5+6 pending, 20+1 waiting
        out_ready = 1'b0;
        beat(1'b0, splat(32'd5), splat(32'd6), 1'b0);
        tick();
        beat(1'b0, splat(32'd20), splat(32'd1), 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_in_ready_%0d", c), VW'(in_ready), VW'(1'b0));
            chk($sformatf("bp_data_%0d", c), out_data, splat(32'd11));
            chk($sformatf("bp_valid_%0d", c), VW'(out_valid), VW'(1'b1));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", VW'(in_ready), VW'(1'b1));
        tick();
        chk("bp_next_valid", VW'(out_valid), VW'(1'b1));
        chk("bp_next_data", out_data, splat(32'd21));
        idle();
        tick();
        chk("bp_drain", VW'(out_valid), VW'(1'b0));

        // Overflow in ADD mode
        beat(1'b0, splat(32'h7FFF_FFFF), splat(32'd1), 1'b0);
        tick();
`ifdef VECTOR_ADD_ACC_SAT_EN
        chk("ovf_pos", out_data, splat(32'h7FFF_FFFF));
`else
        chk("ovf_pos", out_data, splat(32'h8000_0000));
`endif
        beat(1'b0, splat(32'h8000_0000), splat(32'hFFFF_FFFF), 1'b0);
        tick();
`ifdef VECTOR_ADD_ACC_SAT_EN
        chk("ovf_neg", out_data, splat(32'h8000_0000));
`else
        chk("ovf_neg", out_data, splat(32'h7FFF_FFFF));
`endif
        // Even lanes: -1 + 1 = 0 with no carry into odd lanes (3 + 4 = 7)
        for (int i = 0; i < LANES; i++) begin
            mix_a[i*DATA_W +: DATA_W] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd3;
            mix_b[i*DATA_W +: DATA_W] = (i % 2 == 0) ? 32'd1 : 32'd4;
            exp_v[i*DATA_W +: DATA_W] = (i % 2 == 0) ? 32'd0 : 32'd7;
        end
        beat(1'b0, mix_a, mix_b, 1'b0);
        tick();
        chk("lane_isolation", out_data, exp_v);
        idle();
        tick();

        // ACC overflow: 0x7FFFFFFF + 1 + (-1)
        beat(1'b1, splat(32'h7FFF_FFFF), '0, 1'b0);
        tick();
        beat(1'b1, splat(32'd1), '0, 1'b0);
        tick();
        beat(1'b1, splat(32'hFFFF_FFFF), '0, 1'b1);
        tick();
`ifdef VECTOR_ADD_ACC_SAT_EN
        chk("acc_ovf_data", out_data, splat(32'h7FFF_FFFE));
`else
        chk("acc_ovf_data", out_data, splat(32'h7FFF_FFFF));
`endif
        chk("acc_ovf_count", VW'(out_count), VW'(3));
        idle();
        tick();

        // Bubbles and mode toggled mid-group: 3 + 4 + 5 = 12
        beat(1'b1, splat(32'd3), rnd_vec(), 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("bub_hold_1", VW'(out_valid), VW'(1'b0));
        beat(1'b0, splat(32'd4), rnd_vec(), 1'b0);
        tick();
        chk("bub_mode_ignored", VW'(out_valid), VW'(1'b0));
        idle();
        tick();
        tick();
        beat(1'b0, splat(32'd5), rnd_vec(), 1'b1);
        tick();
        chk("bub_valid", VW'(out_valid), VW'(1'b1));
        chk("bub_data", out_data, splat(32'd12));
        chk("bub_count", VW'(out_count), VW'(3));
        idle();
        tick();

        // Reset drops a pending output immediately
        out_ready = 1'b0;
        beat(1'b0, splat(32'd9), splat(32'd9), 1'b0);
        tick();
        idle();
        chk("rstp_pending", VW'(out_valid), VW'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("rstp_valid", VW'(out_valid), VW'(1'b0));
        chk("rstp_data", out_data, '0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Reset mid-group, then fresh groups show no residue
        beat(1'b1, splat(32'd50), '0, 1'b0);
        tick();
        beat(1'b1, splat(32'd60), '0, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("rstg_valid", VW'(out_valid), VW'(1'b0));
        chk("rstg_count", VW'(out_count), '0);
        tick();
        rst = 1'b0;
        tick();
        beat(1'b1, splat(32'd7), '0, 1'b1);
        tick();
        chk("rstg_single_data", out_data, splat(32'd7));
        chk("rstg_single_count", VW'(out_count), VW'(1));
        beat(1'b1, splat(32'd7), '0, 1'b0);
        tick();
        beat(1'b1, splat(32'd1), '0, 1'b1);
        tick();
        chk("rstg_pair_data", out_data, splat(32'd8));
        chk("rstg_pair_count", VW'(out_count), VW'(2));
        idle();
        tick();
        chk("final_idle", VW'(out_valid), VW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
